// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared definitions for the countdown-timer display back-end:
//            active-low 7-segment codes, digit slot indices, the BCD
//            converter state encoding and small conversion helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Active-low segment codes, bit7 = dp, bit6 = g ... bit0 = a
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_O     = 8'hA3;
  localparam logic [7:0] SEG_N     = 8'hAB;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Clearing bit7 lights the decimal point
  localparam logic [7:0] SEG_DP_MASK = 8'h7F;

  // Digit slot indices on the 8-digit panel
  localparam logic [2:0] DIG_SEC_UNITS = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
  localparam logic [2:0] DIG_MIN_UNITS = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
  localparam logic [2:0] DIG_E         = 3'd4;
  localparam logic [2:0] DIG_N         = 3'd5;
  localparam logic [2:0] DIG_O         = 3'd6;
  localparam logic [2:0] DIG_D         = 3'd7;

  // Capture/convert/load sequencing
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } conv_state_t;

  // Two decimal digits is all the panel can show
  function automatic logic [6:0] clamp99(input logic [6:0] value);
    return (value > 7'd99) ? 7'd99 : value;
  endfunction

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential 7-bit binary to two-digit BCD converter. The input is
//            clamped to 99, then 10 is subtracted once per clock while the
//            remainder is 10 or more, counting tens along the way.
// Ports    : clock  - system clock
//            reset  - asynchronous active-high reset
//            start  - latch bin and begin a conversion (wins over a running one)
//            bin    - binary value to convert
//            busy   - conversion in progress
//            valid  - tens/units hold a finished result (held until next start)
//            tens   - BCD tens digit
//            units  - BCD units digit
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       busy,
  output logic       valid,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [6:0] r_rem;
  logic [3:0] r_tens;
  logic       r_active;
  logic       w_ge10;

  assign w_ge10 = (r_rem >= 7'd10);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rem    <= 7'd0;
      r_tens   <= 4'd0;
      r_active <= 1'b0;
    end else if (start) begin
      r_rem    <= clamp99(bin);
      r_tens   <= 4'd0;
      r_active <= 1'b1;
    end else if (r_active && w_ge10) begin
      r_rem    <= r_rem - 7'd10;
      r_tens   <= r_tens + 4'd1;
    end
  end

  // Once the remainder drops below 10 it is the units digit; result is
  // stable from then until the next start.
  assign busy  = r_active && w_ge10;
  assign valid = r_active && !w_ge10;
  assign tens  = r_tens;
  assign units = r_rem[3:0];

endmodule
`default_nettype wire

// File: rtl/timer_display.sv
`default_nettype none
// ============================================================================
// Module   : timer_display
// Purpose  : Display back-end for the countdown timer. Converts live binary
//            minutes/seconds to BCD and scans an 8-digit common-anode
//            7-segment panel showing MM.SS plus "donE" on the upper digits.
// Ports    : clock   - system clock
//            reset   - asynchronous active-high reset
//            min     - minutes, binary (clamped to 99)
//            sec     - seconds, binary (clamped to 99)
//            blink   - flash the MM.SS digits
//            done    - show "donE" on digits 4..7
//            an      - digit enables, active low
//            dec_cat - segment cathodes, active low (bit7 = dp)
// Revision : 1.0 - initial release
// ============================================================================
module timer_display
  import timer_pkg::*;
#(
  parameter int REFRESH_CNT = 50000,
  parameter int BLINK_SLOTS = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  input  logic       blink,
  input  logic       done,
  output logic [7:0] an,
  output logic [7:0] dec_cat
);

  localparam int TICK_W  = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam int BLINK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(REFRESH_CNT - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_SLOTS - 1);

  // --------------------------------------------------------------------------
  // Capture and conversion control
  // --------------------------------------------------------------------------
  conv_state_t r_state, w_next_state;
  logic        w_start, w_load;
  logic [6:0]  w_min_clamped, w_sec_clamped;
  logic [6:0]  r_min_cap, r_sec_cap;
  logic        w_min_busy, w_sec_busy, w_min_valid, w_sec_valid;
  logic [3:0]  w_min_tens, w_min_units, w_sec_tens, w_sec_units;
  logic [3:0]  r_min_tens, r_min_units, r_sec_tens, r_sec_units;

  assign w_min_clamped = clamp99(min);
  assign w_sec_clamped = clamp99(sec);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if ((w_min_clamped != r_min_cap) || (w_sec_clamped != r_sec_cap)) begin
          w_start      = 1'b1;
          w_next_state = CONV;
        end
      end
      CONV: begin
        if (w_min_valid && w_sec_valid && !w_min_busy && !w_sec_busy)
          w_next_state = LOAD;
      end
      LOAD: begin
        w_load       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_min_cap <= 7'd0;
      r_sec_cap <= 7'd0;
    end else if (w_start) begin
      r_min_cap <= w_min_clamped;
      r_sec_cap <= w_sec_clamped;
    end
  end

  bin2bcd_seq u_min_conv (
    .clock (clock),
    .reset (reset),
    .start (w_start),
    .bin   (w_min_clamped),
    .busy  (w_min_busy),
    .valid (w_min_valid),
    .tens  (w_min_tens),
    .units (w_min_units)
  );

  bin2bcd_seq u_sec_conv (
    .clock (clock),
    .reset (reset),
    .start (w_start),
    .bin   (w_sec_clamped),
    .busy  (w_sec_busy),
    .valid (w_sec_valid),
    .tens  (w_sec_tens),
    .units (w_sec_units)
  );

  // All four digits update together so the panel never shows a mixed value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_min_tens  <= 4'd0;
      r_min_units <= 4'd0;
      r_sec_tens  <= 4'd0;
      r_sec_units <= 4'd0;
    end else if (w_load) begin
      r_min_tens  <= w_min_tens;
      r_min_units <= w_min_units;
      r_sec_tens  <= w_sec_tens;
      r_sec_units <= w_sec_units;
    end
  end

  // --------------------------------------------------------------------------
  // Scan counter and blink phase
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0]  r_tick;
  logic [2:0]         r_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic               w_scan_tick;

  assign w_scan_tick = (r_tick == TICK_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick <= '0;
      r_idx  <= 3'd0;
    end else if (w_scan_tick) begin
      r_tick <= '0;
      r_idx  <= r_idx + 3'd1;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!blink) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_scan_tick) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Digit select and segment output registers
  // --------------------------------------------------------------------------
  logic [7:0] w_seg, w_an;
  logic       w_blank;
  logic [7:0] r_an, r_dec_cat;

  always_comb begin
    w_seg   = SEG_BLANK;
    w_blank = 1'b0;
    case (r_idx)
      DIG_SEC_UNITS: w_seg = bcd_to_seg(r_sec_units);
      DIG_SEC_TENS:  w_seg = bcd_to_seg(r_sec_tens);
      DIG_MIN_UNITS: w_seg = bcd_to_seg(r_min_units) & SEG_DP_MASK;
      DIG_MIN_TENS:  w_seg = bcd_to_seg(r_min_tens);
      DIG_E:         w_seg = SEG_E;
      DIG_N:         w_seg = SEG_N;
      DIG_O:         w_seg = SEG_O;
      DIG_D:         w_seg = SEG_D;
      default:       w_seg = SEG_BLANK;
    endcase
    // Upper digits only exist while "donE" is shown; lower ones flash
    if (r_idx >= DIG_E) begin
      if (!done) w_blank = 1'b1;
    end else if (r_blink_phase) begin
      w_blank = 1'b1;
    end
    // A blanked slot also drops its anode so nothing ghosts
    w_an = w_blank ? 8'hFF : ~(8'h01 << r_idx);
    if (w_blank) w_seg = SEG_BLANK;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an      <= 8'hFF;
      r_dec_cat <= 8'hFF;
    end else begin
      r_an      <= w_an;
      r_dec_cat <= w_seg;
    end
  end

  assign an      = r_an;
  assign dec_cat = r_dec_cat;

endmodule
`default_nettype wire

// File: tb/tb_timer_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_display
// Purpose  : Self-checking bench for timer_display with a small refresh and
//            blink period. A behavioural model derives the expected panel
//            image from the cycle count since reset and the decimal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_display;

  localparam int RC = 4;
  localparam int BS = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] min   = 7'd0;
  logic [6:0] sec   = 7'd0;
  logic       blink = 1'b0;
  logic       done  = 1'b0;
  logic [7:0] an;
  logic [7:0] dec_cat;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: edges since reset release, blink ticks since blink rose,
  // the value already on the panel and the value being converted to.
  int m_k, m_bt, m_since;
  int m_old_min, m_old_sec, m_new_min, m_new_sec;
  bit m_switched;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  timer_display #(.REFRESH_CNT(RC), .BLINK_SLOTS(BS)) dut (
    .clock   (clock),
    .reset   (reset),
    .min     (min),
    .sec     (sec),
    .blink   (blink),
    .done    (done),
    .an      (an),
    .dec_cat (dec_cat)
  );

  always #5 clock = ~clock;

  function automatic int clamp(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  // Expected panel pins for one digit slot
  function automatic void model_out(input int idx, input bit ph, input bit dn,
                                    input int mn, input int sc,
                                    output logic [7:0] ea, output logic [7:0] ed);
    bit lit;
    lit = 1'b1;
    case (idx)
      0: ed = seg_tab[sc % 10];
      1: ed = seg_tab[sc / 10];
      2: ed = seg_tab[mn % 10] & 8'h7F;
      3: ed = seg_tab[mn / 10];
      4: ed = 8'h86;
      5: ed = 8'hAB;
      6: ed = 8'hA3;
      default: ed = 8'hA1;
    endcase
    if (idx >= 4 && !dn) lit = 1'b0;
    if (idx < 4 && ph)   lit = 1'b0;
    if (!lit) ed = 8'hFF;
    ea = lit ? ~(8'd1 << idx) : 8'hFF;
  endfunction

  task automatic check_reset_pins(input string tag);
    n_cmp++;
    assert (an === 8'hFF) else begin
      n_bad++;
      $error("FAIL %s an: got %h want FF", tag, an);
    end
    n_cmp++;
    assert (dec_cat === 8'hFF) else begin
      n_bad++;
      $error("FAIL %s dec_cat: got %h want FF", tag, dec_cat);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_pins("reset_async");
    repeat (2) @(posedge clock);
    #1;
    check_reset_pins("reset_held");
    @(negedge clock);
    reset      = 1'b0;
    m_k        = 0;
    m_bt       = 0;
    m_since    = 0;
    m_old_min  = 0;
    m_old_sec  = 0;
    m_switched = 1'b0;
    m_new_min  = clamp(int'(min));
    m_new_sec  = clamp(int'(sec));
  endtask

  task automatic set_val(input int mn, input int sc);
    m_old_min  = m_new_min;
    m_old_sec  = m_new_sec;
    m_new_min  = clamp(mn);
    m_new_sec  = clamp(sc);
    m_since    = 0;
    m_switched = 1'b0;
    min        = 7'(mn);
    sec        = 7'(sc);
  endtask

  // One clock: predict from pre-edge state, advance the model, compare.
  task automatic step(input string tag);
    int         idx_b;
    bit         ph_b, dn_b, bl_b, new_ok, old_ok;
    logic [7:0] ea_n, ed_n, ea_o, ed_o, ea, ed;
    idx_b = (m_k / RC) % 8;
    ph_b  = ((m_bt / BS) % 2) == 1;
    dn_b  = done;
    bl_b  = blink;
    @(posedge clock);
    m_k++;
    m_since++;
    if (!bl_b)              m_bt = 0;
    else if (m_k % RC == 0) m_bt++;
    #1;
    model_out(idx_b, ph_b, dn_b, m_new_min, m_new_sec, ea_n, ed_n);
    model_out(idx_b, ph_b, dn_b, m_old_min, m_old_sec, ea_o, ed_o);
    new_ok = ({an, dec_cat} === {ea_n, ed_n});
    old_ok = ({an, dec_cat} === {ea_o, ed_o});
    if (new_ok && !old_ok) m_switched = 1'b1;
    // Old image is acceptable only until the first new digit and within
    // the conversion latency.
    if (!new_ok && old_ok && !m_switched && m_since <= 12) begin
      ea = ea_o; ed = ed_o;
    end else begin
      ea = ea_n; ed = ed_n;
    end
    n_cmp++;
    assert ({an, dec_cat} === {ea, ed}) else begin
      n_bad++;
      $error("FAIL %s k=%0d idx=%0d: got an=%h dec_cat=%h want an=%h dec_cat=%h",
             tag, m_k, idx_b, an, dec_cat, ea, ed);
    end
  endtask

  initial begin
    m_new_min = 0;
    m_new_sec = 0;
    do_reset();
    step("first_after_reset");
    repeat (35) step("zero_scan");

    set_val(12, 34);
    repeat (64) step("show_12_34");

    set_val(120, 100);
    repeat (48) step("clamp_99_99");

    done = 1'b1;
    set_val(0, 0);
    repeat (48) step("done_0000");
    done = 1'b0;

    set_val(12, 34);
    repeat (40) step("reload_12_34");
    blink = 1'b1;
    repeat (80) step("blink_on");
    blink = 1'b0;
    repeat (40) step("blink_off");

    set_val(12, 59);
    repeat (3) step("pre_abort");
    do_reset();
    repeat (48) step("after_abort");

    for (int i = 0; i < 12; i++) begin
      set_val(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
      done  = 1'($urandom_range(0, 1));
      blink = 1'($urandom_range(0, 1));
      repeat (int'($urandom_range(20, 60))) step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
